// File: rtl/tmds_gearbox_10to4.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_gearbox_10to4
//  Brief    : 10-bit TMDS symbol to 4-bit nibble width converter that feeds
//             a 4:1 DDR output serializer. Bits go out LSB first.
//             Optional bit-slip alignment: define TMDS_GEARBOX_BITSLIP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tmds_gearbox_10to4 #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 4,
    parameter int BUF_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
`ifdef TMDS_GEARBOX_BITSLIP_EN
    input  logic             bitslip,
`endif
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             underflow
);

    localparam int                  c_fill_w = $clog2(BUF_W + 1);
    localparam logic [c_fill_w-1:0] c_out_n  = c_fill_w'(OUT_W);
    localparam logic [c_fill_w-1:0] c_in_n   = c_fill_w'(IN_W);

    logic [BUF_W-1:0]    r_buf;
    logic [c_fill_w-1:0] r_fill;
    logic                r_primed;

    logic [c_fill_w-1:0] w_consume;
    logic [c_fill_w-1:0] w_remain;
    logic                w_take_slip;
    logic                w_accept;
    logic [BUF_W-1:0]    w_in_ext;
    logic [BUF_W-1:0]    w_buf_next;
    logic [c_fill_w-1:0] w_fill_next;
    logic [OUT_W-1:0]    w_nibble;

`ifdef TMDS_GEARBOX_BITSLIP_EN
    localparam logic [c_fill_w-1:0] c_slip_n = c_fill_w'(OUT_W + 1);

    logic r_slip_pend;

    // A pending slip waits for one extra bit so the dropped LSB never
    // leaves a partial nibble behind; with exactly OUT_W bits the slot idles.
    always_comb begin
        w_consume   = '0;
        w_take_slip = 1'b0;
        if (r_slip_pend) begin
            if (r_fill >= c_slip_n) begin
                w_consume   = c_slip_n;
                w_take_slip = 1'b1;
            end
        end else if (r_fill >= c_out_n) begin
            w_consume = c_out_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slip_pend <= 1'b0;
        end else if (w_take_slip) begin
            r_slip_pend <= 1'b0;
        end else if (bitslip) begin
            r_slip_pend <= 1'b1;
        end
    end
`else
    always_comb begin
        w_consume   = '0;
        w_take_slip = 1'b0;
        if (r_fill >= c_out_n) begin
            w_consume = c_out_n;
        end
    end
`endif

    assign w_remain = r_fill - w_consume;

    // Depends on registered fill only, never on in_valid.
    assign in_ready = (int'(w_remain) + IN_W) <= BUF_W;
    assign w_accept = in_valid & in_ready;

    assign w_in_ext    = {{(BUF_W - IN_W){1'b0}}, in_data};
    assign w_buf_next  = (r_buf >> w_consume) |
                         (w_accept ? (w_in_ext << w_remain) : '0);
    assign w_fill_next = w_remain + (w_accept ? c_in_n : '0);
    assign w_nibble    = w_take_slip ? r_buf[OUT_W:1] : r_buf[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else begin
            r_buf  <= w_buf_next;
            r_fill <= w_fill_next;
        end
    end

    // Idle slots emit zero; a missed slot after the first real nibble is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            r_primed  <= 1'b0;
            underflow <= 1'b0;
        end else if (w_consume != '0) begin
            out_data  <= w_nibble;
            out_valid <= 1'b1;
            r_primed  <= 1'b1;
        end else begin
            out_data  <= '0;
            out_valid <= 1'b0;
            if (r_primed) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmds_gearbox_10to4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_gearbox_10to4
//  Brief    : Directed self-checking bench for tmds_gearbox_10to4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_gearbox_10to4;

    logic       clk;
    logic       rst;
    logic [9:0] in_data;
    logic       in_valid;
    logic       bitslip;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       underflow;

    int n_total;
    int n_bad;

    logic [3:0] exp_nib [5];
    logic       exp_rdy [5];

    tmds_gearbox_10to4 #(
        .IN_W  (10),
        .OUT_W (4),
        .BUF_W (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef TMDS_GEARBOX_BITSLIP_EN
        .bitslip   (bitslip),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        bitslip  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_oval", 32'(out_valid), 0);
        check_val("rst_odata", 32'(out_data), 0);
        check_val("rst_uflow", 32'(underflow), 0);
        check_val("rst_ready", 32'(in_ready), 1);
    endtask

    // Alternating 3FF/000 stream started from an empty buffer. With stall set,
    // valid drops in the two cycles before edges 10 and 11; the buffer runs
    // dry, edge 12 is an idle slot and the stream restarts from cycle 11.
    task automatic run_stream(input int n_edges, input bit stall);
        int base;
        int r;
        bit sym;
        bit acc;
        bit uf_exp;
        base   = 0;
        sym    = 1'b0;
        uf_exp = 1'b0;
        for (int e = 1; e <= n_edges; e++) begin
            in_valid = !(stall && (e == 10 || e == 11));
            in_data  = sym ? 10'h000 : 10'h3FF;
            acc      = in_valid && in_ready;
            tick();
            if (acc) sym = ~sym;
            if (stall && e == 12) begin
                base   = 11;
                uf_exp = 1'b1;
            end
            r = e - base;
            if (r < 2) begin
                check_val("st_oval_idle", 32'(out_valid), 0);
            end else begin
                check_val("st_oval", 32'(out_valid), 1);
                check_val("st_odata", 32'(out_data), 32'(exp_nib[(r - 2) % 5]));
            end
            check_val("st_uflow", 32'(underflow), 32'(uf_exp));
            if (!(stall && e == 10)) begin
                check_val("st_ready", 32'(in_ready), (r < 2) ? 1 : 32'(exp_rdy[(r - 2) % 5]));
            end
        end
    endtask

`ifdef TMDS_GEARBOX_BITSLIP_EN
    bit bits_q[$];

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (out_valid) begin
                for (int b = 0; b < 4; b++) bits_q.push_back(out_data[b]);
            end
        end
    endtask

    // Phase (mod 10) of the ones in the last 40 collected bits; -1 if the
    // ones are not exactly one per 10-bit period at a common phase.
    function automatic int tail_phase();
        int ph;
        int ones;
        int n;
        ph   = -1;
        ones = 0;
        n    = bits_q.size();
        for (int i = n - 40; i < n; i++) begin
            if (bits_q[i]) begin
                if (ph < 0) ph = i % 10;
                else if (ph != i % 10) return -1;
                ones++;
            end
        end
        return (ones == 4) ? ph : -1;
    endfunction

    task automatic pulse_slip();
        bitslip = 1'b1;
        adv(1);
        bitslip = 1'b0;
    endtask

    task automatic test_bitslip();
        int p0;
        do_reset();
        in_valid = 1'b1;
        in_data  = 10'h001;
        bits_q.delete();
        adv(30);
        p0 = tail_phase();
        check_val("bs_base_period", 32'(p0 >= 0), 1);
        pulse_slip();
        adv(30);
        check_val("bs_one_slip", 32'(tail_phase()), 32'((p0 + 9) % 10));
        for (int k = 0; k < 9; k++) begin
            pulse_slip();
            adv(15);
        end
        adv(15);
        check_val("bs_ten_slips", 32'(tail_phase()), 32'(p0));
        check_val("bs_oval", 32'(out_valid), 1);
    endtask
`endif

    initial begin
        n_total = 0;
        n_bad   = 0;
        exp_nib = '{4'hF, 4'hF, 4'h3, 4'h0, 4'h0};
        exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        bitslip  = 1'b0;

        // Continuous alternating stream
        do_reset();
        run_stream(22, 1'b0);

        // Single symbol: two nibbles, two leftover bits never emitted
        do_reset();
        in_valid = 1'b1;
        in_data  = 10'b10_1100_0110;
        tick();
        in_valid = 1'b0;
        check_val("one_e1_oval", 32'(out_valid), 0);
        tick();
        check_val("one_e2_odata", 32'(out_data), 32'h6);
        check_val("one_e2_oval", 32'(out_valid), 1);
        tick();
        check_val("one_e3_odata", 32'(out_data), 32'hC);
        check_val("one_e3_uflow", 32'(underflow), 0);
        tick();
        check_val("one_e4_oval", 32'(out_valid), 0);
        check_val("one_e4_odata", 32'(out_data), 0);
        check_val("one_e4_uflow", 32'(underflow), 1);
        tick();
        tick();
        check_val("one_sticky_uflow", 32'(underflow), 1);
        check_val("one_ready", 32'(in_ready), 1);

        // Idle from reset: never primed
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val("idle_oval", 32'(out_valid), 0);
            check_val("idle_odata", 32'(out_data), 0);
            check_val("idle_uflow", 32'(underflow), 0);
        end

        // Stall-induced underflow, then reset mid-stream at fill 12
        do_reset();
        run_stream(14, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_oval", 32'(out_valid), 0);
        check_val("mid_rst_odata", 32'(out_data), 0);
        check_val("mid_rst_uflow", 32'(underflow), 0);
        check_val("mid_rst_ready", 32'(in_ready), 1);
        run_stream(12, 1'b0);

`ifdef TMDS_GEARBOX_BITSLIP_EN
        test_bitslip();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
